xor3_parity_arbiter: RTL
========================

# xor3_parity_arbiter

Shares one `xor3` parity unit between NREQ requesters, one job at a time. The block arbitrates round-robin, latches the winner's word, and feeds two data bits per cycle plus the running accumulator through the 3-input XOR. It reports the word's parity with the requester ID. It sits between the requesting datapath blocks and the single shared parity resource.

## Interface
Parameters:
- NREQ, 4, number of requesters; 2..8.
- WIDTH, 8, data word width; even, ≥2.
- IDW, 3, width of the ID field; must satisfy 2^IDW ≥ NREQ.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level.
- data  input  NREQ*WIDTH  requester i's word is data[i*WIDTH +: WIDTH].
- grant  output  NREQ  one-hot; marks the current owner.
- busy  output  1  high while a job is in progress (BUSY or DONE).
- valid  output  1  one-cycle pulse: result available.
- parity  output  1  parity of the granted word; qualified by valid.
- id  output  IDW  index of the requester that owns the result; qualified by valid.

## Operation
- States are IDLE, BUSY and DONE.
- **IDLE**
  - If req is zero, stay in IDLE.
  - Otherwise pick the winner: the first set req bit at or after the round-robin pointer rr, wrapping NREQ-1→0.
  - On that edge: grant gets the winner's one-hot, sh ← winner's word, acc ← 0, cnt ← 0, id ← winner, rr ← winner+1 mod NREQ. Go to BUSY.
- **BUSY**
  - Each edge: acc ← xor3(acc, sh[0], sh[1]), sh ← sh >> 2, cnt ← cnt+1.
  - On the edge where cnt = WIDTH/2−1, go to DONE.
- **DONE**
  - valid=1 and parity=acc (combinational from registered acc/state).
  - Next edge: grant ← 0, go to IDLE.
- Data is latched at grant. req or data changes after the grant edge do not affect the job; a requester dropping req mid-job still gets its result.
- req is sampled only in IDLE. A requester still holding req after DONE competes again; rr gives the other requesters priority first.
- Reset values: state IDLE, grant 0, busy 0, valid 0, parity 0, id 0, rr 0, acc 0, cnt 0.
- Reset asserted in any state wins on that edge: the job is dropped, no valid is issued, and rr returns to 0.
- Out-of-range IDs never occur because grant is derived only from bits < NREQ.

## Timing
- Edge E0 (IDLE, req≠0): grant and busy rise after E0.
- E1..E(WIDTH/2): the XOR steps.
- valid is high for the cycle after E(WIDTH/2); grant and busy fall after E(WIDTH/2)+1.
- Latency from the request-sampling edge to valid is WIDTH/2+1 cycles.
- There is at least one IDLE cycle between jobs, so back-to-back throughput is one job per WIDTH/2+2 cycles.
- For WIDTH=8: valid appears 5 cycles after the grant edge; job period is 6 cycles.

## Configuration
- Macro: XOR3_ARB_ODD_PARITY_EN.
- Defined: parity = ~acc in DONE (odd-parity bit: makes the word plus parity bit have an odd number of ones).
- Undefined: parity = acc (even parity, i.e. the XOR of all bits).
- Timing, grant behaviour and reset values are identical in both builds.

## Structure
- Shared package xor3_arb_pkg holds:
  - the state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the round-robin pick function (req, rr → winner index);
  - an IDW-width calculation helper.
- One sub-module: the existing `xor3` (ports out, in1, in2, in3), instantiated once with in1=acc, in2=sh[0], in3=sh[1].
- The arbiter, shift register, counter and FSM stay in the top module.

## Test plan
All scenarios use NREQ=4, WIDTH=8.
- **Reset:** hold reset 2 cycles → grant=0, valid=0, busy=0, parity=0, id=0; with req=0, outputs stay idle for 10 cycles.
- **Single job, even build:** req=4'b0010, requester 1 word 8'hA5 → grant=4'b0010 after E0; valid pulses once, 5 cycles after E0, with parity=0, id=1. Repeat with 8'h07 → parity=1.
- **Round-robin:** req=4'b1111 held, all words 8'h01 → grant sequence 0001, 0010, 0100, 1000, 0001, spaced 6 cycles apart; id=0,1,2,3,0; parity=1 each time.
- **Request drop and data change mid-job:** req=4'b0100, word 8'hFF; drop req and change data to 8'h01 one cycle after grant → valid still fires with id=2, parity=0.
- **Reset mid-BUSY:** assert reset at cnt=2 of a job → no valid pulse; all outputs return to reset values. The next req=4'b1000 is granted with rr starting from 0.
- **Odd-parity build:** with XOR3_ARB_ODD_PARITY_EN defined, word 8'hA5 → parity=1, and 8'h07 → parity=0; cycle timing is identical to the even build.

Source files
------------

// File: rtl/xor3_arb_pkg.sv
// xor3_arb_pkg: FSM state encoding, round-robin winner pick and ID width helper
package xor3_arb_pkg;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   function automatic int idw_calc(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
   function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] rr, input int nreq);
      logic [2:0] w;
      logic hit;
      int k;
      w = 3'd0;
      hit = 1'b0;
      for (int i = 0; i < 8; i++) begin
         k = (int'(rr) + i) % nreq;
         if (i < nreq && !hit && req[3'(k)]) begin
            w = 3'(k);
            hit = 1'b1;
         end
      end
      return w;
   endfunction
endpackage

// File: rtl/xor3_parity_arbiter_xor3.sv
// xor3: three-input XOR shared parity step
module xor3 (
   output logic out,
   input  logic in1,
   input  logic in2,
   input  logic in3
);
   assign out = in1 ^ in2 ^ in3;
endmodule

// File: rtl/xor3_parity_arbiter.sv
// xor3_parity_arbiter: round-robin sharing of one xor3 parity unit; define XOR3_ARB_ODD_PARITY_EN for odd parity
module xor3_parity_arbiter
   import xor3_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] data,
   output logic [NREQ-1:0]       grant,
   output logic                  busy,
   output logic                  valid,
   output logic                  parity,
   output logic [IDW-1:0]        id
);
   localparam int CW = $clog2(WIDTH) + 1;
   logic [1:0] state;
   logic [2:0] rr, win;
   logic [WIDTH-1:0] sh;
   logic [CW-1:0] cnt;
   logic acc, acc_nxt;
   xor3 u_xor3 (.out(acc_nxt), .in1(acc), .in2(sh[0]), .in3(sh[1]));
   always_comb win = rr_pick(8'(req), rr, NREQ);
   assign busy  = state != IDLE;
   assign valid = state == DONE;
`ifdef XOR3_ARB_ODD_PARITY_EN
   assign parity = valid & ~acc;
`else
   assign parity = valid & acc;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         grant <= '0;
         id    <= '0;
         rr    <= '0;
         acc   <= 1'b0;
         cnt   <= '0;
         sh    <= '0;
      end else if (state == IDLE) begin
         if (|req) begin
            grant <= NREQ'(1) << win;
            sh    <= data[int'(win)*WIDTH +: WIDTH];
            acc   <= 1'b0;
            cnt   <= '0;
            id    <= IDW'(win);
            rr    <= (int'(win) == NREQ - 1) ? 3'd0 : win + 3'd1;
            state <= BUSY;
         end
      end else if (state == BUSY) begin
         acc   <= acc_nxt;
         sh    <= sh >> 2;
         cnt   <= cnt + CW'(1);
         state <= (cnt == CW'(WIDTH/2 - 1)) ? DONE : BUSY;
      end else begin
         grant <= '0;
         state <= IDLE;
      end
   end
endmodule
